// File: rtl/fifo_pkg.sv
// Shared helpers and read-mode constants for the sync_fifo_fwft family.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Bits needed to address n entries; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; occupancy is tracked by the pointers, so
    // stale contents are never observed and the array can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with programmable thresholds, status pulses and a
// selectable standard / first-word-fall-through output stage.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2,
    parameter int FWFT  = FIFO_STD,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             wr_ack,
    output logic             overflow,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             underflow,
    output logic             empty,
    output logic             almost_empty,
    output logic [AW:0]      data_count
);

    localparam int            DW       = AW + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = DW'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = DW'(AF_TH);
    localparam logic [AW:0]   CNT_AE   = DW'(AE_TH);

    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "sync_fifo_fwft: DEPTH must be >= 2");
    end
    if (AE_TH < 0 || AE_TH >= AF_TH || AF_TH > DEPTH) begin : g_bad_th
        $fatal(1, "sync_fifo_fwft: thresholds must satisfy 0 <= AE_TH < AF_TH <= DEPTH");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_fwft: FWFT must be 0 or 1");
    end

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ack_q, overflow_q, underflow_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             wr_fire, rd_fire;
    logic             mem_wr, mem_rd;
    logic             empty_w;
    logic [WIDTH-1:0] mem_rdata;

    // Pointers wrap on an explicit compare so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_FULL);
    assign wr_fire = wr_en && !full;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = mem_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = mem_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses <= so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_fire;
            overflow_q  <= wr_en && full;
            underflow_q <= rd_en && empty_w;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rdata)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        logic mem_empty, take, load, bypass;

        // count includes the output register, so memory is empty when count == valid.
        assign mem_empty = (count_q == DW'(valid_q));
        assign empty_w   = !valid_q;
        assign rd_fire   = rd_en && valid_q;
        assign take      = !valid_q || rd_fire;
        assign load      = take && !mem_empty;
        assign bypass    = take && mem_empty && wr_fire;
        assign mem_wr    = wr_fire && !bypass;
        assign mem_rd    = load;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else if (load) begin
                dout_q  <= mem_rdata;
                valid_q <= 1'b1;
            end else if (bypass) begin
                dout_q  <= din;
                valid_q <= 1'b1;
            end else if (rd_fire) begin
                valid_q <= 1'b0;
            end
        end
    end else begin : g_std
        assign empty_w = (count_q == '0);
        assign rd_fire = rd_en && !empty_w;
        assign mem_wr  = wr_fire;
        assign mem_rd  = rd_fire;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_fire;
                if (rd_fire) dout_q <= mem_rdata;
            end
        end
    end

    assign empty        = empty_w;
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign data_count   = count_q;
    assign dout         = dout_q;
    assign valid        = valid_q;
    assign wr_ack       = wr_ack_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
